// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding
// and 8N1 frame constants.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        TX_START_BIT = 3'd1,
        TX_DATA_BITS = 3'd2,
        TX_STOP_BIT  = 3'd3,
        CLEANUP      = 3'd4
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data; occupancy
// carries one extra bit so full and empty never alias.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // A full FIFO refuses writes even when a pop lands on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array is deliberately left out of reset; empty/full
    // come from the pointers, so stale contents are never observed.
    always_ff @(posedge i_Clock) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a byte FIFO. Line outputs are registered from
// the current state, so the line trails the FSM by one clock.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [CNT_W-1:0]     clk_count;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [7:0]           tx_data;
    logic [7:0]           fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign o_Ready  = !fifo_full;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .wr_en   (i_TX_DV),
        .wr_data (i_TX_Byte),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            clk_count   <= '0;
            bit_idx     <= '0;
            tx_data     <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by the later
            // assignments in the case arms; last write on the edge wins.
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;

            case (state)
                IDLE: begin
                    clk_count <= '0;
                    bit_idx   <= '0;
                    if (!fifo_empty) begin
                        tx_data <= fifo_rd_data;
                        state   <= TX_START_BIT;
                    end
                end

                TX_START_BIT: begin
                    o_TX_Serial <= 1'b0;
                    o_TX_Active <= 1'b1;
                    if (clk_count == LAST_CNT) begin
                        clk_count <= '0;
                        bit_idx   <= '0;
                        state     <= TX_DATA_BITS;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                TX_DATA_BITS: begin
                    o_TX_Serial <= tx_data[bit_idx];
                    o_TX_Active <= 1'b1;
                    if (clk_count == LAST_CNT) begin
                        clk_count <= '0;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            state   <= TX_STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                TX_STOP_BIT: begin
                    o_TX_Active <= 1'b1;
                    if (clk_count == LAST_CNT) begin
                        clk_count <= '0;
                        state     <= CLEANUP;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                CLEANUP: begin
                    o_TX_Done <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a cycle-timeline model of the
// FIFO and 8N1 framing predicts every output after every clock edge.
module tb_uart_tx_buffered;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_Ready;
    logic       o_TX_Active;
    logic       o_TX_Serial;
    logic       o_TX_Done;

    int errors = 0;
    int checks = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_Ready     (o_Ready),
        .o_TX_Active (o_TX_Active),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Done   (o_TX_Done)
    );

    always #5 i_Clock = ~i_Clock;

    // Model: accepted-byte queue plus the edge at which the current frame was
    // popped; the line is a pure function of the cycles elapsed since the pop.
    logic [7:0] q[$];
    logic [7:0] cur;
    int model_edge;
    int pop_edge;
    int free_edge;

    task automatic model_reset();
        q.delete();
        cur        = 8'h00;
        model_edge = 0;
        pop_edge   = -100000;
        free_edge  = 0;
    endtask

    function automatic int cur_j();
        return model_edge - pop_edge - 1;
    endfunction

    task automatic model_step(input logic dv, input logic [7:0] b);
        bit rdy;
        rdy = (q.size() < DEPTH);
        model_edge++;
        if (model_edge >= free_edge && q.size() > 0) begin
            cur       = q.pop_front();
            pop_edge  = model_edge;
            free_edge = model_edge + FRAME + 2;
        end
        if (dv && rdy)
            q.push_back(b);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, model_edge);
        end
    endtask

    task automatic check_outputs();
        int  j;
        int  k;
        logic es, ea, ed;
        j  = cur_j();
        es = 1'b1;
        ea = 1'b0;
        ed = 1'b0;
        if (j >= 0 && j < FRAME) begin
            k  = j / C;
            ea = 1'b1;
            if (k == 0)      es = 1'b0;
            else if (k <= 8) es = cur[k-1];
            else             es = 1'b1;
        end else if (j == FRAME) begin
            ed = 1'b1;
        end
        check("serial", o_TX_Serial, es);
        check("active", o_TX_Active, ea);
        check("done",   o_TX_Done,   ed);
        check("ready",  o_Ready,     (q.size() < DEPTH));
    endtask

    task automatic tick(input logic dv, input logic [7:0] b);
        i_TX_DV   = dv;
        i_TX_Byte = b;
        @(posedge i_Clock);
        model_step(dv, b);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_serial"}, o_TX_Serial, 1'b1);
        check({tag, "_active"}, o_TX_Active, 1'b0);
        check({tag, "_done"},   o_TX_Done,   1'b0);
        check({tag, "_ready"},  o_Ready,     1'b1);
    endtask

    // Idle until the model says the queue is empty and the transmitter free.
    task automatic drain();
        for (int n = 0; n < 400 && !(q.size() == 0 && model_edge >= free_edge + 1); n++)
            tick(1'b0, 8'($urandom));
    endtask

    initial begin
        logic [7:0] burst [7];
        burst = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81, 8'h5A, 8'hC7};
        model_reset();

        // Reset state, held across a few edges.
        repeat (3) @(posedge i_Clock);
        #1;
        check_reset_values("reset");
        i_Reset = 1'b0;

        // Single 0x55 frame.
        tick(1'b1, 8'h55);
        for (int n = 0; n < FRAME + 6; n++)
            tick(1'b0, 8'($urandom));

        // Consecutive burst: FIFO fills, later writes dropped, order kept.
        drain();
        for (int i = 0; i < 7; i++)
            tick(1'b1, burst[i]);
        drain();

        // Keep writing through frames so pops coincide with writes,
        // including on a full FIFO.
        for (int n = 0; n < 3 * (FRAME + 2); n++)
            tick(1'b1, 8'($urandom));
        drain();

        // Randomized traffic with random byte changes when not strobing.
        for (int n = 0; n < 600; n++)
            tick(($urandom_range(0, 2) == 0), 8'($urandom));
        drain();

        // Reset during data bit 4 of 0xC3 with two bytes queued.
        tick(1'b1, 8'hC3);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        for (int n = 0; n < 60 && cur_j() != 5 * C + 1; n++)
            tick(1'b0, 8'($urandom));
        check("midreset_in_bit4", (cur_j() == 5 * C + 1), 1'b1);
        #2 i_Reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(posedge i_Clock);
        #1;
        check_reset_values("held_reset");
        i_Reset = 1'b0;
        model_reset();

        // Long idle: no stray frames after the abort.
        for (int n = 0; n < 100; n++)
            tick(1'b0, 8'($urandom));

        // One more frame to confirm normal operation after reset.
        tick(1'b1, 8'h96);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of byte entries buffered; power of two from 2 to 16.
REQ-003 SHALL have port i_Clock, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port i_Reset, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port i_TX_DV, input, 1, write strobe for i_TX_Byte.
REQ-006 SHALL have port i_TX_Byte, input, 8, byte to transmit.
REQ-007 SHALL have port o_Ready, output, 1, high when the FIFO is not full.
REQ-008 SHALL have port o_TX_Active, output, 1, high while a frame is on the line.
REQ-009 SHALL have port o_TX_Serial, output, 1, serial line; idle high.
REQ-010 SHALL have port o_TX_Done, output, 1, one-cycle pulse after each stop bit completes.

Function
REQ-011 SHALL accept a byte into the FIFO on a clock edge where i_TX_DV=1 and o_Ready=1; i_TX_DV while o_Ready=0 SHALL be dropped with no state change.
REQ-012 SHALL send each frame as 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL implement states IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT, CLEANUP.
REQ-014 IDLE: o_TX_Serial=1, o_TX_Active=0. If FIFO is non-empty, pop the head into a shift register and go to TX_START_BIT. Otherwise stay in IDLE.
REQ-015 TX_START_BIT: drive 0. After CLKS_PER_BIT cycles, go to TX_DATA_BITS with bit index 0.
REQ-016 TX_DATA_BITS: drive data[bit index] for CLKS_PER_BIT cycles, then increment the index. After index 7 completes, go to TX_STOP_BIT.
REQ-017 TX_STOP_BIT: drive 1 for CLKS_PER_BIT cycles, then go to CLEANUP.
REQ-018 CLEANUP: lasts exactly 1 cycle with o_TX_Done=1 and o_TX_Serial=1, then go to IDLE.
REQ-019 Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE SHALL be popped at edge k+1. o_TX_Serial SHALL go low after edge k+2.
REQ-020 Back-to-back frames SHALL be separated by exactly 2 idle-high cycles (CLEANUP plus IDLE pop), beyond the stop bit.
REQ-021 o_TX_Active SHALL be 1 in TX_START_BIT, TX_DATA_BITS and TX_STOP_BIT, and 0 otherwise.
REQ-022 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and reset to 0 on each bit boundary.
REQ-023 Simultaneous write and pop on a non-full FIFO SHALL both take effect, leaving the occupancy unchanged.
REQ-024 A write on the cycle the FIFO is full SHALL be rejected even if a pop occurs in the same cycle.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with one extra bit so that full and empty are unambiguous.
REQ-026 Bytes SHALL transmit in write order; a byte captured in the shift register SHALL be immune to later i_TX_Byte changes.

Reset
REQ-027 i_Reset=1 SHALL asynchronously force state=IDLE, empty FIFO, counters=0, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_Ready=1.
REQ-028 Reset mid-frame SHALL abort the frame immediately (line high) and discard all buffered bytes.
REQ-029 After reset deasserts, the first edge SHALL behave as IDLE with an empty FIFO.

Structure
REQ-030 A shared package SHALL hold the state encoding constants (IDLE=0 … CLEANUP=4, 3-bit) and the frame constant DATA_BITS=8.
REQ-031 The FIFO SHALL be a sub-module named uart_tx_fifo (parameters WIDTH, DEPTH; ports wr_en, wr_data, rd_en, rd_data, full, empty), sharing clock and reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Write 0x55 once -> line low from edge k+2, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, o_TX_Done single pulse.
REQ-033 Write 0xA3, 0x0F, 0xFF, 0x00, 0x81 on consecutive cycles -> o_Ready falls after the FIFO fills; any byte written while o_Ready=0 is dropped; accepted bytes appear in order, frames 2 idle cycles apart.
REQ-034 Fill the FIFO while the FSM pops on the same edge as a write -> occupancy unchanged, no byte lost or duplicated.
REQ-035 Assert i_Reset in the middle of data bit 4 of 0xC3 with 2 bytes queued -> o_TX_Serial=1 immediately, no o_TX_Done, no further frames, o_Ready=1.
REQ-036 Idle with no writes for 100 cycles -> o_TX_Serial stays 1, o_TX_Active=0, o_TX_Done=0 throughout.
